// File: rtl/memory_access_stage.sv
// Memory-stage controller: accepts LW/SW/PUSH/POP requests, drives a registered-read
// data memory, owns the stack pointer and reports address/stack faults.
module memory_access_stage #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned STACK_TOP = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_address,
  input  logic [31:0] req_store_data,
  input  logic [2:0]  req_dest_reg,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [2:0]  resp_dest_reg,
  output logic        resp_is_load,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] stack_pointer
);

  localparam logic [1:0] OP_LW   = 2'b00;
  localparam logic [1:0] OP_SW   = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_POP  = 2'b11;

  localparam logic [1:0] FAULT_NONE  = 2'b00;
  localparam logic [1:0] FAULT_RANGE = 2'b01;
  localparam logic [1:0] FAULT_OVER  = 2'b10;
  localparam logic [1:0] FAULT_UNDER = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  state_t      state, state_next;
  logic        accept;
  logic        is_load_op;
  logic [31:0] eff_address;
  logic [1:0]  check_code;
  logic        load_q;
  logic [2:0]  dest_q;

  assign req_ready  = (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign is_load_op = (req_op == OP_LW) || (req_op == OP_POP);

  always_comb begin
    eff_address = req_address;
    check_code  = FAULT_NONE;
    case (req_op)
      OP_LW, OP_SW: begin
        if (req_address >= MEM_DEPTH) check_code = FAULT_RANGE;
      end
      OP_PUSH: begin
        eff_address = stack_pointer - 32'd1;
        if (stack_pointer == '0) check_code = FAULT_OVER;
      end
      default: begin
        eff_address = stack_pointer;
        if (stack_pointer == STACK_TOP) check_code = FAULT_UNDER;
      end
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && check_code == FAULT_NONE) state_next = ACCESS;
      ACCESS:  state_next = load_q ? WAIT : IDLE;
      WAIT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Enables and response fields default low every cycle so each is a single-cycle pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_address      <= '0;
      mem_write_data   <= '0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      resp_valid       <= 1'b0;
      resp_data        <= '0;
      resp_dest_reg    <= '0;
      resp_is_load     <= 1'b0;
      fault            <= 1'b0;
      fault_code       <= FAULT_NONE;
      stack_pointer    <= STACK_TOP;
      load_q           <= 1'b0;
      dest_q           <= '0;
    end else begin
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      resp_valid       <= 1'b0;
      resp_data        <= '0;
      resp_dest_reg    <= '0;
      resp_is_load     <= 1'b0;
      fault            <= 1'b0;
      fault_code       <= FAULT_NONE;
      case (state)
        IDLE: begin
          if (accept) begin
            dest_q <= req_dest_reg;
            load_q <= is_load_op;
            if (check_code != FAULT_NONE) begin
              resp_valid    <= 1'b1;
              resp_dest_reg <= req_dest_reg;
              fault         <= 1'b1;
              fault_code    <= check_code;
            end else begin
              mem_address      <= eff_address;
              mem_write_data   <= req_store_data;
              mem_write_enable <= !is_load_op;
              mem_read_enable  <= is_load_op;
              if (req_op == OP_PUSH) stack_pointer <= stack_pointer - 32'd1;
              if (req_op == OP_POP)  stack_pointer <= stack_pointer + 32'd1;
            end
          end
        end
        ACCESS: begin
          if (!load_q) begin
            resp_valid    <= 1'b1;
            resp_dest_reg <= dest_q;
          end
        end
        WAIT: begin
          resp_valid    <= 1'b1;
          resp_data     <= mem_read_data;
          resp_dest_reg <= dest_q;
          resp_is_load  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: registered-read memory model plus an in-order
// request-level reference model (memory array, stack pointer, response timing).
module tb_memory_access_stage;

  localparam int unsigned MEM_DEPTH = 256;
  localparam int unsigned STACK_TOP = 256;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_address;
  logic [31:0] req_store_data;
  logic [2:0]  req_dest_reg;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [2:0]  resp_dest_reg;
  logic        resp_is_load;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] stack_pointer;

  memory_access_stage #(.MEM_DEPTH(MEM_DEPTH), .STACK_TOP(STACK_TOP)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_address(req_address), .req_store_data(req_store_data), .req_dest_reg(req_dest_reg),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_dest_reg(resp_dest_reg),
    .resp_is_load(resp_is_load), .fault(fault), .fault_code(fault_code),
    .stack_pointer(stack_pointer)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  tag;
  } req_t;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [2:0]  tag;
    logic        is_load;
    logic        flt;
    logic [1:0]  code;
  } rsp_t;

  req_t        reqs[$];
  acc_t        acc_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] ref_mem [0:255];
  logic [31:0] env_mem [0:255];
  logic        mem_init;
  int          sp_exp;
  int          checks;
  int          errors;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] init_word(input int i);
    return 32'(i * 7 + 3);
  endfunction

  // Data memory: one-cycle registered read, garbage on the read bus when not reading.
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
    end else if (mem_write_enable) begin
      env_mem[mem_address[7:0]] <= mem_write_data;
    end
    mem_read_data <= mem_read_enable ? env_mem[mem_address[7:0]] : $urandom;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [1:0] op, input logic [31:0] addr,
                     input logic [31:0] data, input logic [2:0] tag);
    req_t r;
    r.op = op; r.addr = addr; r.data = data; r.tag = tag;
    reqs.push_back(r);
  endtask

  // Request-level model: acceptance decided at negedge t, effects visible from t+1.
  task automatic model_accept(input req_t rq, input int t, output int busy);
    acc_t a;
    rsp_t r;
    r.cyc = t + 1; r.data = '0; r.tag = rq.tag; r.is_load = 1'b0; r.flt = 1'b0; r.code = 2'b00;
    a.cyc = t + 1; a.we = 1'b0; a.addr = '0; a.data = rq.data;
    case (rq.op)
      2'b00: if (rq.addr >= MEM_DEPTH) r.code = 2'b01;
             else begin a.addr = rq.addr; r.data = ref_mem[rq.addr[7:0]]; r.is_load = 1'b1; end
      2'b01: if (rq.addr >= MEM_DEPTH) r.code = 2'b01;
             else begin a.we = 1'b1; a.addr = rq.addr; ref_mem[rq.addr[7:0]] = rq.data; end
      2'b10: if (sp_exp == 0) r.code = 2'b10;
             else begin sp_exp--; a.we = 1'b1; a.addr = 32'(sp_exp); ref_mem[sp_exp] = rq.data; end
      default: if (sp_exp == int'(STACK_TOP)) r.code = 2'b11;
             else begin a.addr = 32'(sp_exp); r.data = ref_mem[sp_exp]; r.is_load = 1'b1; sp_exp++; end
    endcase
    if (r.code != 2'b00) begin
      r.flt = 1'b1;
      busy = t + 1;
    end else begin
      acc_q.push_back(a);
      r.cyc = r.is_load ? t + 3 : t + 2;
      busy = r.cyc;
    end
    rsp_q.push_back(r);
  endtask

  task automatic run_stream(input bit gaps, input int max_cycles);
    int   t, idx, n, busy_until;
    bit   advance;
    acc_t a;
    rsp_t r;
    t = 0; idx = 0; busy_until = 0; advance = 1'b1; n = reqs.size();
    while ((idx < n || rsp_q.size() > 0 || acc_q.size() > 0) && t < max_cycles) begin
      @(negedge clock);
      check("req_ready", 32'(req_ready), 32'(t >= busy_until));
      check("stack_pointer", stack_pointer, 32'(sp_exp));
      if (acc_q.size() > 0 && acc_q[0].cyc == t) begin
        a = acc_q.pop_front();
        check("mem_write_enable", 32'(mem_write_enable), 32'(a.we));
        check("mem_read_enable", 32'(mem_read_enable), 32'(!a.we));
        check("mem_address", mem_address, a.addr);
        if (a.we) check("mem_write_data", mem_write_data, a.data);
      end else begin
        check("mem_write_enable_idle", 32'(mem_write_enable), 32'd0);
        check("mem_read_enable_idle", 32'(mem_read_enable), 32'd0);
      end
      if (rsp_q.size() > 0 && rsp_q[0].cyc == t) begin
        r = rsp_q.pop_front();
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_data", resp_data, r.data);
        check("resp_dest_reg", 32'(resp_dest_reg), 32'(r.tag));
        check("resp_is_load", 32'(resp_is_load), 32'(r.is_load));
        check("fault", 32'(fault), 32'(r.flt));
        check("fault_code", 32'(fault_code), 32'(r.code));
      end else begin
        check("resp_valid_idle", 32'(resp_valid), 32'd0);
      end
      if (advance) begin
        if (idx < n && !(gaps && $urandom_range(0, 3) == 0)) begin
          req_valid = 1'b1;
          req_op = reqs[idx].op; req_address = reqs[idx].addr;
          req_store_data = reqs[idx].data; req_dest_reg = reqs[idx].tag;
          advance = 1'b0;
        end else begin
          // Scramble fields while idle: anything not sampled at acceptance must be ignored.
          req_valid = 1'b0;
          req_op = 2'($urandom); req_address = $urandom;
          req_store_data = $urandom; req_dest_reg = 3'($urandom);
          advance = (idx < n);
        end
      end
      if (req_valid && req_ready) begin
        model_accept(reqs[idx], t, busy_until);
        idx++;
        advance = 1'b1;
      end
      t++;
    end
    req_valid = 1'b0;
    check("stream_accepted", 32'(idx), 32'(n));
    check("stream_drained", 32'(rsp_q.size() + acc_q.size()), 32'd0);
    reqs.delete();
    acc_q.delete();
    rsp_q.delete();
  endtask

  initial begin
    checks = 0; errors = 0;
    sp_exp = int'(STACK_TOP);
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    mem_init = 1'b1;
    reset = 1'b1; req_valid = 1'b0; req_op = '0;
    req_address = '0; req_store_data = '0; req_dest_reg = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0; mem_init = 1'b0;
    @(negedge clock);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_stack_pointer", stack_pointer, 32'd256);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_write_data", mem_write_data, 32'd0);
    check("rst_mem_enables", 32'({mem_write_enable, mem_read_enable}), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_fields", 32'({resp_dest_reg, resp_is_load, fault, fault_code}), 32'd0);

    add(2'b01, 32'd1, 32'd32, 3'd0);
    add(2'b00, 32'd1, 32'd0, 3'd3);
    run_stream(1'b0, 100);

    add(2'b00, 32'd300, 32'd0, 3'd5);
    add(2'b00, 32'd255, 32'd0, 3'd4);
    add(2'b01, 32'd256, 32'd9, 3'd6);
    run_stream(1'b0, 100);

    add(2'b10, 32'd0, 32'h0000_00A5, 3'd1);
    add(2'b11, 32'd0, 32'd0, 3'd2);
    add(2'b11, 32'd0, 32'd0, 3'd7);
    run_stream(1'b0, 100);

    // Held valid: LW then SW to the same word; the load must see the old value.
    add(2'b00, 32'd7, 32'd0, 3'd1);
    add(2'b01, 32'd7, 32'hDEAD_BEEF, 3'd2);
    add(2'b00, 32'd7, 32'd0, 3'd3);
    run_stream(1'b0, 100);

    add(2'b10, 32'd0, 32'h0000_0077, 3'd0);
    run_stream(1'b0, 100);

    req_op = 2'b00; req_address = 32'd1; req_dest_reg = 3'd6; req_valid = 1'b1;
    check("rw_ready_before", 32'(req_ready), 32'd1);
    @(negedge clock);
    req_valid = 1'b0;
    check("rw_read_enable", 32'(mem_read_enable), 32'd1);
    @(negedge clock);
    check("rw_wait_no_resp", 32'(resp_valid), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    sp_exp = int'(STACK_TOP);
    check("rw_resp_valid", 32'(resp_valid), 32'd0);
    check("rw_req_ready", 32'(req_ready), 32'd1);
    check("rw_stack_pointer", stack_pointer, 32'd256);
    @(negedge clock);
    check("rw_resp_valid_after", 32'(resp_valid), 32'd0);
    add(2'b00, 32'd255, 32'd0, 3'd1);
    run_stream(1'b0, 100);

    for (int i = 0; i < 260; i++) add(2'b10, 32'd0, $urandom, 3'(i));
    run_stream(1'b0, 2000);
    check("sp_full", stack_pointer, 32'd0);
    for (int i = 0; i < 260; i++) add(2'b11, 32'd0, 32'd0, 3'(i));
    run_stream(1'b0, 2000);
    check("sp_empty", stack_pointer, 32'd256);

    for (int i = 0; i < 120; i++)
      add(2'($urandom_range(0, 3)), 32'($urandom_range(0, 300)), $urandom, 3'($urandom_range(0, 7)));
    run_stream(1'b1, 3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- Memory-stage controller sitting directly upstream of the data memory.
- Accepts load/store/push/pop requests from the execute stage over a valid/ready handshake and drives the data memory's address, write-data and read/write enables.
- Captures the memory's registered read data and hands a one-cycle result pulse to write-back.
- Owns the stack pointer and reports address/stack faults.

Parameters:
MEM_DEPTH, 256, number of 32-bit words in data memory; word addresses 0..MEM_DEPTH-1 are legal.
STACK_TOP, 256, reset value of the stack pointer (empty stack); must be <= MEM_DEPTH.

Ports:
clock  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  stage can accept a request (high only in IDLE)
req_op  input  2  00 LW, 01 SW, 10 PUSH, 11 POP
req_address  input  32  word address for LW/SW (ignored for PUSH/POP)
req_store_data  input  32  data for SW/PUSH
req_dest_reg  input  3  destination register tag, passed through
mem_address  output  32  to data memory address bus
mem_write_data  output  32  to data memory input bus
mem_read_data  input  32  from data memory output bus; valid the cycle after mem_read_enable is sampled
mem_write_enable  output  1  data memory write enable
mem_read_enable  output  1  data memory read enable
resp_valid  output  1  one-cycle result pulse to write-back
resp_data  output  32  loaded/popped data (0 for stores and faults)
resp_dest_reg  output  3  tag of the completing request
resp_is_load  output  1  write-back must write resp_data (LW/POP without fault)
fault  output  1  completing request faulted (qualified by resp_valid)
fault_code  output  2  01 address out of range, 10 stack overflow, 11 stack underflow, 00 none
stack_pointer  output  32  current SP

Behaviour:
- Reset (synchronous, active-high) values:
  - state = IDLE, stack_pointer = STACK_TOP.
  - All other outputs 0, except req_ready = 1 once in IDLE.
- All mem_* and resp_* outputs are registered.
- FSM states IDLE, ACCESS, WAIT.
- IDLE:
  - req_ready = 1.
  - Accept on the edge where req_valid & req_ready; latch op, dest tag and store data.
  - Compute the effective address: LW/SW = req_address; PUSH = SP-1; POP = SP.
- Fault checks at acceptance (no memory enables ever asserted):
  - LW/SW with req_address >= MEM_DEPTH -> code 01.
  - PUSH with SP == 0 -> code 10.
  - POP with SP == STACK_TOP -> code 11.
  - On fault: the next edge raises resp_valid = 1, fault = 1, resp_is_load = 0, resp_data = 0; state stays IDLE; SP unchanged.
- Non-faulting request:
  - Accept edge N: mem_address and mem_write_data driven; mem_write_enable = 1 for SW/PUSH, mem_read_enable = 1 for LW/POP; state -> ACCESS.
  - Edge N+1: memory samples the enables. Enables drop to 0, so each enable is high exactly one cycle.
  - Edge N+1, stores: resp_valid = 1, resp_is_load = 0; state -> IDLE.
  - Edge N+1, loads: state -> WAIT.
  - WAIT, edge N+2: resp_data = mem_read_data, resp_is_load = 1, resp_valid = 1; state -> IDLE.
- Stack pointer updates:
  - SP <= SP-1 for PUSH on the acceptance edge.
  - SP <= SP+1 for POP on the acceptance edge.
- resp_valid is high for exactly one cycle; write-back applies no backpressure.
- resp_dest_reg = latched tag for every response, including faults.
- A new request may be accepted in the same cycle resp_valid is high (req_ready already 1 in IDLE).
- Requests are never reordered or dropped; a held req_valid waits until req_ready.
- req_op/req_address/req_store_data are sampled only at acceptance; later changes are ignored.
- Reset mid-operation:
  - Next edge forces IDLE, clears enables and resp_valid, restores SP.
  - A write whose enable is high on the reset edge is committed by the memory; no response is generated.
- Addresses are word addresses; no byte lanes, no alignment faults. SP arithmetic is 32-bit and protected by the overflow/underflow checks, so it never wraps.

Test Plan:
- Reset for 2 cycles, then release -> req_ready = 1, stack_pointer = 256, all mem_* and resp_* = 0.
- SW addr 1 data 32, then LW addr 1 tag 3:
  - SW: mem_write_enable high exactly 1 cycle with mem_address = 1, mem_write_data = 32; resp_valid with resp_is_load = 0 one edge later.
  - LW: resp_valid 2 edges after the read-enable cycle with resp_data = 32, resp_dest_reg = 3, resp_is_load = 1.
- LW addr 300 tag 5 -> resp_valid the next edge with fault = 1, fault_code = 01, resp_dest_reg = 5; mem_read_enable never asserted.
- PUSH 0xA5, then POP tag 2, then POP:
  - PUSH writes address 255, SP = 255.
  - First POP reads address 255, resp_data = 0xA5, SP = 256.
  - Second POP gives fault_code = 11 with SP still 256.
- Hold req_valid with LW then SW back-to-back:
  - Second request is accepted only when req_ready returns.
  - Memory sees the read before the write.
  - Exactly two resp_valid pulses, in order.
- Assert reset during WAIT of a LW -> no resp_valid, state IDLE, req_ready = 1, SP = 256; a following LW completes normally.
